// File: rtl/slv_req_arb.sv
// ============================================================================
// Module  : slv_req_arb
// Purpose : Round-robin arbiter sharing one slave access port among N_MST
//           requesters. Optional ack timeout: SLV_REQ_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module slv_req_arb #(
   parameter int N_MST          = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        soft_rst,
   input  logic [N_MST-1:0]            m_req_vld,
   input  logic [N_MST-1:0]            m_wr_en,
   input  logic [N_MST-1:0]            m_rd_en,
   input  logic [N_MST*ADDR_WIDTH-1:0] m_addr,
   input  logic [N_MST*DATA_WIDTH-1:0] m_wr_data,
   output logic [N_MST-1:0]            m_ack_vld,
   output logic [N_MST-1:0]            m_err,
   output logic [DATA_WIDTH-1:0]       m_rd_data,
   output logic                        s_req_vld,
   output logic                        s_wr_en,
   output logic                        s_rd_en,
   output logic [ADDR_WIDTH-1:0]       s_addr,
   output logic [DATA_WIDTH-1:0]       s_wr_data,
   input  logic                        s_ack_vld,
   input  logic                        s_err,
   input  logic [DATA_WIDTH-1:0]       s_rd_data,
   output logic [((N_MST > 1) ? $clog2(N_MST) : 1)-1:0] grant_id,
   output logic                        busy
);

   localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [GW-1:0]         r_ptr;
   logic [GW-1:0]         r_gnt;
   logic                  r_wr;
   logic                  r_rd;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_any;
   logic                  w_any_hi;
   logic [GW-1:0]         w_win_hi;
   logic [GW-1:0]         w_win_lo;
   logic [GW-1:0]         w_win;
   logic                  w_bad_type;
   logic                  w_on_bus;
   logic                  w_ack_take;
   logic                  w_timeout;
   logic [GW-1:0]         w_ptr_nxt;
   logic [N_MST-1:0]      w_gnt_oh;

   // r_ptr holds the first index to search, so after reset index 0 wins and
   // after a grant the search resumes just past the last winner.
   always_comb begin
      w_any_hi = 1'b0;
      w_win_hi = '0;
      w_win_lo = '0;
      for (int i = N_MST - 1; i >= 0; i--) begin
         if (m_req_vld[i]) begin
            w_win_lo = GW'(i);
         end
         if (m_req_vld[i] && (GW'(i) >= r_ptr)) begin
            w_win_hi = GW'(i);
            w_any_hi = 1'b1;
         end
      end
   end

   assign w_any      = |m_req_vld;
   assign w_win      = w_any_hi ? w_win_hi : w_win_lo;
   assign w_bad_type = (m_wr_en[w_win] == m_rd_en[w_win]);
   assign w_on_bus   = (r_state == ISSUE) || (r_state == WAIT_ACK);
   assign w_ack_take = s_ack_vld && w_on_bus;
   assign w_ptr_nxt  = (r_gnt == GW'(N_MST - 1)) ? '0 : (r_gnt + GW'(1));
   assign w_gnt_oh   = {{(N_MST-1){1'b0}}, 1'b1} << r_gnt;

`ifdef SLV_REQ_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (soft_rst || (r_state == ISSUE)) begin
         r_tmo_cnt <= '0;
      end else if (r_state == WAIT_ACK) begin
         r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
   end

   assign w_timeout = (r_state == WAIT_ACK) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (soft_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = w_bad_type ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            w_state_nxt = s_ack_vld ? RESP : WAIT_ACK;
         end
         WAIT_ACK: begin
            if (s_ack_vld || w_timeout) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else if (soft_rst) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if ((r_state == IDLE) && w_any) begin
            r_gnt   <= w_win;
            r_wr    <= m_wr_en[w_win];
            r_rd    <= m_rd_en[w_win];
            r_addr  <= m_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= m_wr_data[w_win*DATA_WIDTH +: DATA_WIDTH];
            // An illegal type is answered directly as an error.
            r_err   <= w_bad_type;
            r_rdata <= '0;
         end
         if (w_ack_take) begin
            r_rdata <= r_rd ? s_rd_data : '0;
            r_err   <= s_err;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
         if (r_state == RESP) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   assign s_req_vld = (r_state == ISSUE);
   assign s_wr_en   = w_on_bus & r_wr;
   assign s_rd_en   = w_on_bus & r_rd;
   assign s_addr    = w_on_bus ? r_addr  : '0;
   assign s_wr_data = w_on_bus ? r_wdata : '0;

   assign m_ack_vld = (r_state == RESP) ? w_gnt_oh : '0;
   assign m_err     = ((r_state == RESP) && r_err) ? w_gnt_oh : '0;
   assign m_rd_data = (r_state == RESP) ? r_rdata : '0;

   assign grant_id  = r_gnt;
   assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
